// File: rtl/sd_apb_master.sv
// Single-outstanding APB master feeding the SD-card controller's register port.
// Latency: request accepted at edge N -> SETUP N+1, ACCESS N+2.., response held from N+3 (zero-wait).
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready; a hung slave is aborted by a watchdog.
//
// Ports
//   clk, nreset                      : rising-edge clock, async active-low reset
//   req_valid/req_ready              : request handshake (addr, write, wdata)
//   rsp_valid/rsp_ready              : held response (rdata, error)
//   apb_PADDR..apb_PWDATA            : APB master outputs (all registered)
//   apb_PREADY, apb_PRDATA           : APB slave inputs, only looked at during ACCESS
module sd_apb_master #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CW      = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [4:0]  apb_PADDR,
  output logic        apb_PSEL,
  output logic        apb_PENABLE,
  output logic        apb_PWRITE,
  output logic [31:0] apb_PWDATA,
  input  logic        apb_PREADY,
  input  logic [31:0] apb_PRDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Counter value on the last ACCESS cycle we are willing to wait.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_req;
  logic          done_ok;
  logic          done_abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_req   = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_req = 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the final watchdog
        // cycle is reported as a normal transfer.
        if (apb_PREADY) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          done_abort = 1'b1;
          state_d    = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and APB strobes are flopped from the next state so every
  // output comes straight from a register and reset clears them at once.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      apb_PADDR   <= '0;
      apb_PSEL    <= 1'b0;
      apb_PENABLE <= 1'b0;
      apb_PWRITE  <= 1'b0;
      apb_PWDATA  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready   <= (state_d == IDLE);
      rsp_valid   <= (state_d == RESP);
      apb_PSEL    <= (state_d == SETUP) || (state_d == ACCESS);
      apb_PENABLE <= (state_d == ACCESS);

      // Address/data registers double as the APB outputs and simply hold
      // between transfers.
      if (load_req) begin
        apb_PADDR  <= req_addr;
        apb_PWRITE <= req_write;
        apb_PWDATA <= req_wdata;
      end

      if (done_ok) begin
        rsp_rdata <= apb_PWRITE ? 32'd0 : apb_PRDATA;
        rsp_error <= 1'b0;
      end else if (done_abort) begin
        rsp_rdata <= 32'd0;
        rsp_error <= 1'b1;
      end
    end
  end

endmodule
